// File: rtl/intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intersection_ctrl
// Purpose  : Two-way intersection sequencer (A main, B side) with demand-driven
//            min/max green, fixed yellow and all-red clearance. Optional
//            pedestrian walk phase enabled by defining PED_WALK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module intersection_ctrl #(
    parameter int CLOCK_FREQ  = 50,
    parameter int GREEN_MIN_S = 5,
    parameter int GREEN_MAX_S = 15,
    parameter int YELLOW_S    = 1,
    parameter int ALLRED_S    = 1
`ifdef PED_WALK_EN
    ,
    parameter int WALK_S      = 4
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
`ifdef PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic [2:0] state_o
);

    localparam logic [31:0] c_GMIN = 32'(CLOCK_FREQ * GREEN_MIN_S);
    localparam logic [31:0] c_GMAX = 32'(CLOCK_FREQ * GREEN_MAX_S);
    localparam logic [31:0] c_YEL  = 32'(CLOCK_FREQ * YELLOW_S);
    localparam logic [31:0] c_CLR  = 32'(CLOCK_FREQ * ALLRED_S);
`ifdef PED_WALK_EN
    localparam logic [31:0] c_WALK = 32'(CLOCK_FREQ * WALK_S);
`endif

    localparam logic [2:0] c_RED    = 3'b001;
    localparam logic [2:0] c_GREEN  = 3'b010;
    localparam logic [2:0] c_YELLOW = 3'b100;

    typedef enum logic [2:0] {
        ST_ALLRED_A = 3'd0,
        ST_A_GREEN  = 3'd1,
        ST_A_YELLOW = 3'd2,
        ST_ALLRED_B = 3'd3,
        ST_B_GREEN  = 3'd4,
        ST_B_YELLOW = 3'd5,
        ST_PED_WALK = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        dem_a_q, dem_a_d;
    logic        dem_b_q, dem_b_d;
`ifdef PED_WALK_EN
    logic        dem_p_q, dem_p_d;
    logic        to_b_q,  to_b_d;
`endif

    logic w_opp_a;
    logic w_opp_b;
    logic w_min_done;
    logic w_max_done;
    logic w_green;

    always_comb begin
        w_opp_a    = dem_b_q | req_b;
        w_opp_b    = dem_a_q | req_a;
        w_min_done = (timer_q >= c_GMIN - 32'd1);
        w_max_done = (timer_q >= c_GMAX - 32'd1);
        w_green    = (state_q == ST_A_GREEN) || (state_q == ST_B_GREEN);
    end

    // Next state, timer and demand latches
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 32'd1;
        dem_a_d = dem_a_q;
        dem_b_d = dem_b_q;
`ifdef PED_WALK_EN
        dem_p_d = dem_p_q;
        to_b_d  = to_b_q;
`endif

        case (state_q)
            ST_ALLRED_A: begin
                if (timer_q == c_CLR - 32'd1) begin
                    state_d = ST_A_GREEN;
`ifdef PED_WALK_EN
                    if (dem_p_q) begin
                        state_d = ST_PED_WALK;
                        to_b_d  = 1'b0;
                    end
`endif
                end
            end
            ST_A_GREEN: begin
                if (w_opp_a && ((w_min_done && !req_a) || w_max_done)) begin
                    state_d = ST_A_YELLOW;
                end
            end
            ST_A_YELLOW: begin
                if (timer_q == c_YEL - 32'd1) begin
                    state_d = ST_ALLRED_B;
                end
            end
            ST_ALLRED_B: begin
                if (timer_q == c_CLR - 32'd1) begin
                    state_d = ST_B_GREEN;
`ifdef PED_WALK_EN
                    if (dem_p_q) begin
                        state_d = ST_PED_WALK;
                        to_b_d  = 1'b1;
                    end
`endif
                end
            end
            ST_B_GREEN: begin
                if (w_opp_b && ((w_min_done && !req_b) || w_max_done)) begin
                    state_d = ST_B_YELLOW;
                end
            end
            ST_B_YELLOW: begin
                if (timer_q == c_YEL - 32'd1) begin
                    state_d = ST_ALLRED_A;
                end
            end
`ifdef PED_WALK_EN
            ST_PED_WALK: begin
                if (timer_q == c_WALK - 32'd1) begin
                    state_d = to_b_q ? ST_B_GREEN : ST_A_GREEN;
                end
            end
`endif
            default: begin
                state_d = ST_ALLRED_A;
            end
        endcase

        // A resting green holds its timer at the max-green threshold so late
        // opposing demand is served on the very next cycle.
        if (state_d != state_q) begin
            timer_d = 32'd0;
        end else if (w_green && w_max_done) begin
            timer_d = timer_q;
        end

        if (req_a && (state_q != ST_A_GREEN)) begin
            dem_a_d = 1'b1;
        end
        if (req_b && (state_q != ST_B_GREEN)) begin
            dem_b_d = 1'b1;
        end
        if ((state_d == ST_A_GREEN) && (state_q != ST_A_GREEN)) begin
            dem_a_d = 1'b0;
        end
        if ((state_d == ST_B_GREEN) && (state_q != ST_B_GREEN)) begin
            dem_b_d = 1'b0;
        end
`ifdef PED_WALK_EN
        if (ped_req && (state_q != ST_PED_WALK)) begin
            dem_p_d = 1'b1;
        end
        if ((state_d == ST_PED_WALK) && (state_q != ST_PED_WALK)) begin
            dem_p_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ALLRED_A;
            timer_q <= 32'd0;
            dem_a_q <= 1'b0;
            dem_b_q <= 1'b0;
`ifdef PED_WALK_EN
            dem_p_q <= 1'b0;
            to_b_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dem_a_q <= dem_a_d;
            dem_b_q <= dem_b_d;
`ifdef PED_WALK_EN
            dem_p_q <= dem_p_d;
            to_b_q  <= to_b_d;
`endif
        end
    end

    // Outputs depend on the state register alone
    always_comb begin
        light_a = c_RED;
        light_b = c_RED;
        case (state_q)
            ST_A_GREEN:  light_a = c_GREEN;
            ST_A_YELLOW: light_a = c_YELLOW;
            ST_B_GREEN:  light_b = c_GREEN;
            ST_B_YELLOW: light_b = c_YELLOW;
            default:     ;
        endcase
        state_o = state_q;
`ifdef PED_WALK_EN
        walk    = (state_q == ST_PED_WALK);
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_ctrl
// Purpose  : Scoreboard bench for intersection_ctrl: directed scenarios plus
//            random demand, checked against a phase-ring reference model.
//            Define PED_WALK_EN to include the pedestrian phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intersection_ctrl;

    localparam int GMIN = 4;
    localparam int GMAX = 8;
    localparam int YEL  = 2;
    localparam int CLR  = 2;
    localparam int WALK = 4;
`ifdef PED_WALK_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b100;

    logic       clk = 1'b0;
    logic       reset, req_a, req_b, ped_req;
    logic [2:0] light_a, light_b, state_o;
    logic       walk;
`ifndef PED_WALK_EN
    assign walk = 1'b0;
`endif

    intersection_ctrl #(
        .CLOCK_FREQ (2),
        .GREEN_MIN_S(2),
        .GREEN_MAX_S(4),
        .YELLOW_S   (1),
        .ALLRED_S   (1)
`ifdef PED_WALK_EN
        ,
        .WALK_S     (2)
`endif
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req_a  (req_a),
        .req_b  (req_b),
`ifdef PED_WALK_EN
        .ped_req(ped_req),
        .walk   (walk),
`endif
        .light_a(light_a),
        .light_b(light_b),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] la;
        logic [2:0] lb;
        logic [2:0] st;
        logic       wk;
        logic       da;
        logic       db;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: the cycle is a ring of six phases; greens have no fixed
    // length, and a walk detour may be inserted after either clearance.
    int         ring_dur [6] = '{CLR, 0, YEL, CLR, 0, YEL};
    logic [2:0] la_tbl   [6] = '{RED, GREEN, YELLOW, RED, RED, RED};
    logic [2:0] lb_tbl   [6] = '{RED, RED, RED, RED, GREEN, YELLOW};
    int m_idx  = 0;
    int m_age  = 0;
    bit m_walk = 1'b0;
    bit m_da = 1'b0, m_db = 1'b0, m_dp = 1'b0;

    task automatic model_step(input bit r, input bit ra, input bit rb, input bit rp);
        bit a_grn, b_grn, adv, own, opp;
        if (r) begin
            m_idx = 0; m_age = 0; m_walk = 1'b0;
            m_da = 1'b0; m_db = 1'b0; m_dp = 1'b0;
            return;
        end
        a_grn = !m_walk && (m_idx == 1);
        b_grn = !m_walk && (m_idx == 4);
        if (m_walk) begin
            adv = (m_age == WALK - 1);
        end else if (a_grn || b_grn) begin
            own = a_grn ? ra : rb;
            opp = a_grn ? (m_db | rb) : (m_da | ra);
            adv = opp && (((m_age >= GMIN - 1) && !own) || (m_age >= GMAX - 1));
        end else begin
            adv = (m_age == ring_dur[m_idx] - 1);
        end
        if (ra && !a_grn) m_da = 1'b1;
        if (rb && !b_grn) m_db = 1'b1;
        if (rp && !m_walk) m_dp = 1'b1;
        if (!adv) begin
            if (!(a_grn || b_grn) || (m_age < GMAX - 1)) m_age++;
            return;
        end
        m_age = 0;
        if (m_walk) begin
            m_walk = 1'b0;
            m_idx  = m_idx + 1;
        end else if ((m_idx == 0 || m_idx == 3) && PED_EN && m_dp) begin
            m_walk = 1'b1;
            m_dp   = 1'b0;
        end else begin
            m_idx = (m_idx + 1) % 6;
        end
        if (!m_walk && m_idx == 1) m_da = 1'b0;
        if (!m_walk && m_idx == 4) m_db = 1'b0;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.la = m_walk ? RED : la_tbl[m_idx];
        o.lb = m_walk ? RED : lb_tbl[m_idx];
        o.st = m_walk ? 3'd6 : 3'(m_idx);
        o.wk = m_walk;
        o.da = m_da;
        o.db = m_db;
        return o;
    endfunction

    // Apply one cycle of inputs at a falling edge; returns at the next one
    task automatic drive(input bit r, input bit ra, input bit rb, input bit rp);
        reset   = r;
        req_a   = ra;
        req_b   = rb;
        ped_req = rp;
        model_step(r, ra, rb, rp);
        exp_q.push_back(model_obs());
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic measure(input logic [2:0] la, input logic [2:0] lb, input logic wk,
                           input bit ra, input bit rb, output int cnt);
        cnt = 0;
        while (light_a == la && light_b == lb && walk == wk && cnt < 200) begin
            cnt++;
            drive(1'b0, ra, rb, 1'b0);
        end
    endtask

    task automatic wait_lights(input string name, input logic [2:0] la, input logic [2:0] lb);
        int n;
        n = 0;
        while (!(light_a == la && light_b == lb) && n < 100) begin
            n++;
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check(name, {29'd0, light_a}, {29'd0, la});
    endtask

    // Monitor: compares every registered output cycle against the queue
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {light_a, light_b, state_o, walk, dut.dem_a_q, dut.dem_b_q};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL scoreboard t=%0t: got la=%b lb=%b st=%0d walk=%b dem_a=%b dem_b=%b, want la=%b lb=%b st=%0d walk=%b dem_a=%b dem_b=%b",
                             $time, a.la, a.lb, a.st, a.wk, a.da, a.db,
                             e.la, e.lb, e.st, e.wk, e.da, e.db);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit rr, ra, rb, rp, ha, hb;
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; ped_req = 1'b0;
        ha = 1'b0; hb = 1'b0;
        @(negedge clk);

        // Reset, then rest in A green with no demand
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_state", {29'd0, state_o}, 32'd0);
        check("reset_lights", {26'd0, light_a, light_b}, {26'd0, RED, RED});
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("clear_2nd_cycle", {26'd0, light_a, light_b}, {26'd0, RED, RED});
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("first_green", {26'd0, light_a, light_b}, {26'd0, GREEN, RED});
        repeat (110) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("rest_a_state", {29'd0, state_o}, 32'd1);

        // req_b pulse on the first A green cycle
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("s2_green_entry", {29'd0, light_a}, {29'd0, GREEN});
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        measure(GREEN, RED, 1'b0, 1'b0, 1'b0, cnt);
        check("s2_a_green_len", cnt + 1, 32'd4);
        measure(YELLOW, RED, 1'b0, 1'b0, 1'b0, cnt);
        check("s2_a_yellow_len", cnt, 32'd2);
        measure(RED, RED, 1'b0, 1'b0, 1'b0, cnt);
        check("s2_allred_len", cnt, 32'd2);
        check("s2_b_green", {26'd0, light_a, light_b}, {26'd0, RED, GREEN});
        check("s2_dem_b_clear", {31'd0, dut.dem_b_q}, 32'd0);

        // Opposing pulse while A rests on cycle 20
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        wait_lights("s3_reach_a_green", GREEN, RED);
        repeat (19) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("s3_yellow_next", {29'd0, light_a}, {29'd0, YELLOW});
        check("s3_state", {29'd0, state_o}, 32'd2);

        // Own demand held: green ends at max
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        measure(GREEN, RED, 1'b0, 1'b1, 1'b1, cnt);
        check("s4_gmax_len", cnt, 32'd8);
        check("s4_then_yellow", {29'd0, light_a}, {29'd0, YELLOW});

        // Reset during B yellow drops the pending A demand
        wait_lights("s5_reach_b_green", RED, GREEN);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        wait_lights("s5_reach_b_yellow", RED, YELLOW);
        check("s5_dem_a_set", {31'd0, dut.dem_a_q}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("s5_state", {29'd0, state_o}, 32'd0);
        check("s5_lights", {26'd0, light_a, light_b}, {26'd0, RED, RED});
        check("s5_dem_a_lost", {31'd0, dut.dem_a_q}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("s5_a_green", {26'd0, light_a, light_b}, {26'd0, GREEN, RED});
        repeat (30) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("s5_resting", {29'd0, state_o}, 32'd1);

`ifdef PED_WALK_EN
        // Pedestrian detour between A and B
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        measure(YELLOW, RED, 1'b0, 1'b0, 1'b0, cnt);
        check("s6_yellow_len", cnt, 32'd2);
        measure(RED, RED, 1'b0, 1'b0, 1'b0, cnt);
        check("s6_allred_len", cnt, 32'd2);
        measure(RED, RED, 1'b1, 1'b0, 1'b0, cnt);
        check("s6_walk_len", cnt, 32'd4);
        check("s6_b_green", {25'd0, light_a, light_b, walk}, {25'd0, RED, GREEN, 1'b0});
`endif

        // Random demand traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) ha = ~ha;
            if ($urandom_range(0, 24) == 0) hb = ~hb;
            rr = ($urandom_range(0, 299) == 0);
            ra = ha | ($urandom_range(0, 19) == 0);
            rb = hb | ($urandom_range(0, 19) == 0);
            rp = PED_EN && ($urandom_range(0, 39) == 0);
            drive(rr, ra, rb, rp);
        end

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
